// File: rtl/mp_reg_file_pkg.sv
// mp_reg_file_pkg -- shared types and default sizes for mp_reg_file.
//   clr_state_e : clear-sweep FSM states (IDLE, CLEAR)
//   DEF_DATA_W  : default register width
//   DEF_ADDR_W  : default address width (depth = 2**ADDR_W)
package mp_reg_file_pkg;
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 4;
endpackage

// File: rtl/mp_reg_file_clr.sv
// mp_reg_file_clr -- clear-sweep sequencer for mp_reg_file.
// Walks idx 0..DEPTH-1, one entry per clock, asking the storage to zero it.
// Ports:
//   clk     : clock, all updates on posedge
//   rst     : synchronous active-high reset; starts a fresh sweep
//   clr     : start (or restart) a sweep
//   busy    : sweep in progress (straight from the state register)
//   clr_we  : zero rf[clr_idx] on this edge
//   clr_idx : entry being cleared
module mp_reg_file_clr
  import mp_reg_file_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_idx
);
  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  clr_state_e        r_state;
  clr_state_e        w_state_nxt;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] w_idx_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CLEAR;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      IDLE: begin
        if (clr) begin
          w_state_nxt = CLEAR;
          w_idx_nxt   = '0;
        end
      end
      CLEAR: begin
        // A new clr request restarts from entry 0, stretching busy.
        if (clr) begin
          w_idx_nxt = '0;
        end else if (r_idx == LAST_IDX) begin
          w_state_nxt = IDLE;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end
      default: begin
        w_state_nxt = CLEAR;
        w_idx_nxt   = '0;
      end
    endcase
  end

  assign busy    = (r_state == CLEAR);
  assign clr_we  = busy;
  assign clr_idx = r_idx;
endmodule

// File: rtl/mp_reg_file.sv
// mp_reg_file -- 2-write / 2-read register file with a sweeping clear.
// Build option: define MP_REG_FILE_BYPASS_EN to forward same-cycle write
// data onto the read ports (port 2 over port 1).
// Ports:
//   clk, rst      : clock, synchronous active-high reset (starts a clear sweep)
//   clr           : one-cycle request to (re)start a clear sweep
//   we1/wa1/wd1   : write port 1
//   we2/wa2/wd2   : write port 2 (wins an address collision)
//   a1/rd1, a2/rd2: combinational read ports (0 while busy)
//   busy          : clear sweep in progress; writes ignored
module mp_reg_file
  import mp_reg_file_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd1,
  input  logic              we2,
  input  logic [ADDR_W-1:0] wa2,
  input  logic [DATA_W-1:0] wd2,
  input  logic [ADDR_W-1:0] a1,
  input  logic [ADDR_W-1:0] a2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              busy
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_rf [DEPTH];

  logic              w_busy;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_idx;
  logic              w_wen1;
  logic              w_wen2;

  mp_reg_file_clr #(.ADDR_W(ADDR_W)) u_clr (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .busy    (w_busy),
    .clr_we  (w_clr_we),
    .clr_idx (w_clr_idx)
  );

  // Effective user writes: dropped while sweeping, on a reset edge, and to
  // the hardwired zero entry.
  assign w_wen1 = we1 && !w_busy && !rst && !((ZERO_REG != 0) && (wa1 == '0));
  assign w_wen2 = we2 && !w_busy && !rst && !((ZERO_REG != 0) && (wa2 == '0));

  // Port 2 is assigned last so it wins when both hit the same entry.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_rf[w_clr_idx] <= '0;
    end else begin
      if (w_wen1) r_rf[wa1] <= wd1;
      if (w_wen2) r_rf[wa2] <= wd2;
    end
  end

  function automatic logic [DATA_W-1:0] rd_port(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = r_rf[a];
`ifdef MP_REG_FILE_BYPASS_EN
    // Forward only writes that will actually land this edge.
    if (w_wen1 && (wa1 == a)) v = wd1;
    if (w_wen2 && (wa2 == a)) v = wd2;
`endif
    if (w_busy || ((ZERO_REG != 0) && (a == '0))) v = '0;
    return v;
  endfunction

  always_comb rd1 = rd_port(a1);
  always_comb rd2 = rd_port(a2);

  assign busy = w_busy;
endmodule

// File: tb/tb_mp_reg_file.sv
module tb_mp_reg_file;
  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst, clr, we1, we2;
  logic [AW-1:0] wa1, wa2, a1, a2;
  logic [DW-1:0] wd1, wd2;
  logic [DW-1:0] rd1, rd2, zrd1, zrd2;
  logic          busy, zbusy;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: an array per variant and a count of busy cycles left.
  logic [DW-1:0] m0 [DEPTH];
  logic [DW-1:0] mz [DEPTH];
  int            m_cnt = 0;

  always #5 clk = ~clk;

  mp_reg_file #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .we2(we2), .wa2(wa2), .wd2(wd2),
    .a1(a1), .a2(a2), .rd1(rd1), .rd2(rd2), .busy(busy)
  );

  mp_reg_file #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dutz (
    .clk(clk), .rst(rst), .clr(clr),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .we2(we2), .wa2(wa2), .wd2(wd2),
    .a1(a1), .a2(a2), .rd1(zrd1), .rd2(zrd2), .busy(zbusy)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input bit z, input logic [AW-1:0] a);
    if (m_cnt > 0) return '0;
    if (z && a == 0) return '0;
`ifdef MP_REG_FILE_BYPASS_EN
    if (!rst && we2 && wa2 == a) return wd2;
    if (!rst && we1 && wa1 == a) return wd1;
`endif
    return z ? mz[a] : m0[a];
  endfunction

  // Apply one clock edge to the model using the inputs presented at the edge.
  task automatic model_edge();
    if (rst || clr) begin
      // Whole array reads as zero once the sweep is done; nothing written
      // in between can survive, so the model clears it up front.
      m_cnt = DEPTH;
      for (int i = 0; i < DEPTH; i++) begin
        m0[i] = '0;
        mz[i] = '0;
      end
    end else if (m_cnt > 0) begin
      m_cnt--;
    end else begin
      if (we1) begin m0[wa1] = wd1; if (wa1 != 0) mz[wa1] = wd1; end
      if (we2) begin m0[wa2] = wd2; if (wa2 != 0) mz[wa2] = wd2; end
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".busy"},  {{(DW-1){1'b0}}, busy},  {{(DW-1){1'b0}}, m_cnt > 0});
    chk({tag, ".zbusy"}, {{(DW-1){1'b0}}, zbusy}, {{(DW-1){1'b0}}, m_cnt > 0});
    chk({tag, ".rd1"},  rd1,  exp_rd(1'b0, a1));
    chk({tag, ".rd2"},  rd2,  exp_rd(1'b0, a2));
    chk({tag, ".zrd1"}, zrd1, exp_rd(1'b1, a1));
    chk({tag, ".zrd2"}, zrd2, exp_rd(1'b1, a2));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_outs(tag);
  endtask

  task automatic idle_in();
    rst = 0; clr = 0; we1 = 0; we2 = 0;
    wa1 = '0; wa2 = '0; wd1 = '0; wd2 = '0;
  endtask

  initial begin
    idle_in();
    a1 = '0; a2 = '0;
    for (int i = 0; i < DEPTH; i++) begin m0[i] = '0; mz[i] = '0; end

    // Reset: two cycles, then busy for exactly DEPTH cycles.
    rst = 1;
    tick("rst0");
    tick("rst1");
    chk("rst.busy_after", {31'd0, busy}, 32'd1);
    rst = 0;
    for (int i = 0; i < DEPTH; i++) begin
      a1 = AW'(i);
      if (i < DEPTH - 1) begin
        tick("sweep");
        chk("sweep.busy_hi", {31'd0, busy}, 32'd1);
      end else begin
        tick("sweep_end");
        chk("sweep.busy_lo", {31'd0, busy}, 32'd0);
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      a1 = AW'(i); #1;
      chk("post_rst.rd1", rd1, 32'd0);
    end

    // Dual write.
    we1 = 1; wa1 = 3; wd1 = 32'hAAAA_0001;
    we2 = 1; wa2 = 5; wd2 = 32'h5555_0002;
    tick("dual_wr");
    idle_in(); a1 = 3; a2 = 5; #1;
    chk("dual.rd1", rd1, 32'hAAAA_0001);
    chk("dual.rd2", rd2, 32'h5555_0002);

    // Collision: port 2 wins.
    we1 = 1; wa1 = 7; wd1 = 32'h11;
    we2 = 1; wa2 = 7; wd2 = 32'h22;
    tick("coll_wr");
    idle_in(); a1 = 7; #1;
    chk("coll.rd1", rd1, 32'h22);

    // Non-bypass timing: old value until after the edge.
    we2 = 1; wa2 = 4; wd2 = 32'hCAFE; a1 = 4; #1;
    check_outs("byp_pre");
    tick("byp_edge");
    idle_in(); #1;
    chk("byp.after", rd1, 32'hCAFE);

    // Zero register behaviour.
    we1 = 1; wa1 = 0; wd1 = 32'h1234;
    we2 = 1; wa2 = 1; wd2 = 32'h1234;
    tick("zero_wr");
    idle_in(); a1 = 0; a2 = 1; #1;
    chk("zero.z_rd1", zrd1, 32'h0);
    chk("zero.z_rd2", zrd2, 32'h1234);
    chk("zero.n_rd1", rd1, 32'h1234);
    check_outs("zero");

    // Clear mid-use; writes during busy dropped.
    we1 = 1; wa1 = 9; wd1 = 32'hDEAD;
    tick("dead_wr");
    idle_in(); clr = 1;
    tick("clr_pulse");
    clr = 0; we1 = 1; wa1 = 9; wd1 = 32'hBEEF; a1 = 9;
    for (int i = 0; i < DEPTH; i++) tick("clr_sweep");
    idle_in(); #1;
    chk("clr.busy", {31'd0, busy}, 32'd0);
    chk("clr.rd9", rd1, 32'h0);

    // Restart by clr and by rst mid-sweep.
    clr = 1; tick("clr_a");
    clr = 0; for (int i = 0; i < 5; i++) tick("clr_b");
    clr = 1; tick("clr_restart");
    clr = 0; for (int i = 0; i < 8; i++) tick("clr_c");
    rst = 1; tick("rst_mid");
    rst = 0; for (int i = 0; i < DEPTH + 2; i++) tick("rst_mid_sweep");

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      clr = ($urandom_range(0, 59) == 0);
      we1 = $urandom_range(0, 1) == 1;
      we2 = $urandom_range(0, 1) == 1;
      wa1 = AW'($urandom_range(0, DEPTH - 1));
      wa2 = ($urandom_range(0, 3) == 0) ? wa1 : AW'($urandom_range(0, DEPTH - 1));
      wd1 = $urandom;
      wd2 = $urandom;
      a1  = AW'($urandom_range(0, DEPTH - 1));
      a2  = AW'($urandom_range(0, DEPTH - 1));
      #1;
      check_outs("rnd_pre");
      tick("rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
